// File: rtl/ce_sync_pkg.sv
// ce_sync_pkg: shared types and constants for the ce_sync_fifo consumer stage.
//   rx_state_t : upstream (receive) handshake FSM states
//   tx_state_t : downstream (transmit) handshake FSM states
//   KEEP/DELETE: encodings of the Exb keep flag
package ce_sync_pkg;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_RET  = 2'd2
  } tx_state_t;

  localparam logic KEEP   = 1'b1;
  localparam logic DELETE = 1'b0;

endpackage

// File: rtl/ce_sync_fifo_hs_sync.sv
// hs_sync: STAGES-deep single-bit synchronizer for an asynchronous
// handshake level, with asynchronous active-low clear.
// Ports:
//   i_clk   - sampling clock, rising edge
//   i_rst_n - asynchronous active-low clear of every stage
//   i_d     - asynchronous level input
//   o_q     - synchronized level (i_d delayed by STAGES flops)
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ce_sync_fifo.sv
// ce_sync_fifo: clocked consumer behind a self-timed eliminating C-element.
// Accepts packets on a four-phase Send_in/Ack_out handshake, drops those
// with Exb_in=DELETE (after acknowledging them), buffers kept packets in a
// DEPTH-entry FIFO and re-emits them on a four-phase Send_out/Ack_in
// handshake.
// Ports:
//   CP, MR_n           - clock (rising) and async active-low master reset
//   Send_in, Data_in,  - upstream request, bundled data and keep flag
//   Exb_in, Ack_out      and the upstream acknowledge
//   Send_out, Data_out,- downstream request, data and acknowledge
//   Ack_in
//   Count, Full, Empty - FIFO occupancy and its decodes
//   Drop_cnt           - saturating count of deleted packets
//   o_dbg_rx_state,    - current RX / TX FSM state for observation
//   o_dbg_tx_state
// Handshakes: each side is four-phase. A request rises, the acknowledge
// rises, the request falls, the acknowledge falls; data is valid from the
// request rising until the acknowledge rising. Incoming levels are only
// used after the SYNC_STAGES synchronizers.
module ce_sync_fifo
  import ce_sync_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_W      = 16
) (
  input  logic                       CP,
  input  logic                       MR_n,
  input  logic                       Send_in,
  input  logic [WIDTH-1:0]           Data_in,
  input  logic                       Exb_in,
  output logic                       Ack_out,
  output logic                       Send_out,
  output logic [WIDTH-1:0]           Data_out,
  input  logic                       Ack_in,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Full,
  output logic                       Empty,
  output logic [DROP_W-1:0]          Drop_cnt,
  output logic                       o_dbg_rx_state,
  output logic [1:0]                 o_dbg_tx_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             w_s;
  logic             w_a;
  rx_state_t        r_rx_state, w_rx_next;
  tx_state_t        r_tx_state, w_tx_next;
  logic             w_wr, w_drop, w_ack_set, w_ack_clr;
  logic             w_load, w_pop;
  logic             w_full, w_empty;
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [DROP_W-1:0] r_drop;
  logic             r_ack, r_send;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_mem [DEPTH];

  hs_sync #(.STAGES(SYNC_STAGES)) u_sync_send (
    .i_clk(CP), .i_rst_n(MR_n), .i_d(Send_in), .o_q(w_s)
  );

  hs_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .i_clk(CP), .i_rst_n(MR_n), .i_d(Ack_in), .o_q(w_a)
  );

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // RX: a delete is always accepted; a keep waits for space.
  always_comb begin
    w_rx_next = r_rx_state;
    w_wr      = 1'b0;
    w_drop    = 1'b0;
    w_ack_set = 1'b0;
    w_ack_clr = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_s) begin
          if (Exb_in == DELETE) begin
            w_drop    = 1'b1;
            w_ack_set = 1'b1;
            w_rx_next = RX_ACK;
          end else if (!w_full) begin
            w_wr      = 1'b1;
            w_ack_set = 1'b1;
            w_rx_next = RX_ACK;
          end
        end
      end
      RX_ACK: begin
        if (!w_s) begin
          w_ack_clr = 1'b1;
          w_rx_next = RX_IDLE;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // TX: the head entry is popped on the acknowledge, not on the load, so
  // Count includes the word currently presented on Data_out. The extra !w_a
  // guard keeps Send_out from rising against a stale acknowledge.
  always_comb begin
    w_tx_next = r_tx_state;
    w_load    = 1'b0;
    w_pop     = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_empty && !w_a) begin
          w_load    = 1'b1;
          w_tx_next = TX_SEND;
        end
      end
      TX_SEND: begin
        if (w_a) begin
          w_pop     = 1'b1;
          w_tx_next = TX_RET;
        end
      end
      TX_RET: begin
        if (!w_a) w_tx_next = TX_IDLE;
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n) begin
      r_rx_state <= RX_IDLE;
      r_tx_state <= TX_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_drop     <= '0;
      r_ack      <= 1'b0;
      r_send     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_rx_state <= w_rx_next;
      r_tx_state <= w_tx_next;
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop != {DROP_W{1'b1}})) r_drop <= r_drop + DROP_W'(1);
      if (w_ack_set) r_ack <= 1'b1;
      else if (w_ack_clr) r_ack <= 1'b0;
      if (w_load) begin
        r_send     <= 1'b1;
        r_data_out <= r_mem[r_rptr];
      end else if (w_pop) begin
        r_send     <= 1'b0;
      end
    end
  end

  // Storage has no reset; its contents are meaningless until written.
  always_ff @(posedge CP) begin
    if (w_wr) r_mem[r_wptr] <= Data_in;
  end

  assign Ack_out        = r_ack;
  assign Send_out       = r_send;
  assign Data_out       = r_data_out;
  assign Count          = r_count;
  assign Full           = w_full;
  assign Empty          = w_empty;
  assign Drop_cnt       = r_drop;
  assign o_dbg_rx_state = r_rx_state;
  assign o_dbg_tx_state = r_tx_state;

endmodule

// File: tb/tb_ce_sync_fifo.sv
// tb_ce_sync_fifo: bench for ce_sync_fifo (WIDTH=16, DEPTH=8, SYNC_STAGES=2,
// DROP_W=4). An upstream driver task sends packets, a downstream responder
// process acknowledges them and compares each emitted word with the
// expected-word queue.
module tb_ce_sync_fifo;
  import ce_sync_pkg::*;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int SS = 2;
  localparam int DW = 4;

  // clock / reset
  logic CP = 1'b0;
  logic MR_n;
  always #5 CP = ~CP;

  logic          Send_in, Exb_in, Ack_in;
  logic [W-1:0]  Data_in, Data_out;
  logic          Ack_out, Send_out, Full, Empty;
  logic [3:0]    Count;
  logic [DW-1:0] Drop_cnt;
  logic          dbg_rx;
  logic [1:0]    dbg_tx;

  ce_sync_fifo #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(SS), .DROP_W(DW)) dut (
    .CP(CP), .MR_n(MR_n),
    .Send_in(Send_in), .Data_in(Data_in), .Exb_in(Exb_in), .Ack_out(Ack_out),
    .Send_out(Send_out), .Data_out(Data_out), .Ack_in(Ack_in),
    .Count(Count), .Full(Full), .Empty(Empty), .Drop_cnt(Drop_cnt),
    .o_dbg_rx_state(dbg_rx), .o_dbg_tx_state(dbg_tx)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  bit resp_en = 1'b0;
  int resp_min = 0;
  int resp_max = 0;
  int rs = 0;
  int n_seen = 0;
  int max_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // downstream responder: samples on negedge, acks after a random delay
  initial begin
    int dly;
    Ack_in = 1'b0;
    dly = 0;
    forever begin
      @(negedge CP);
      if (int'(Count) > max_count) max_count = int'(Count);
      if (!MR_n) begin
        Ack_in = 1'b0;
        rs = 0;
      end else begin
        case (rs)
          0: if (resp_en && Send_out) begin
            if (exp_q.size() == 0) check("unexpected_out", {16'h0, Data_out}, 32'hFFFF_FFFF);
            else check("data_out", {16'h0, Data_out}, {16'h0, exp_q.pop_front()});
            n_seen++;
            dly = $urandom_range(resp_max, resp_min);
            rs = 1;
          end
          1: if (dly <= 1) begin Ack_in = 1'b1; rs = 2; end else dly--;
          2: if (!Send_out) begin Ack_in = 1'b0; rs = 0; end
          default: rs = 0;
        endcase
      end
    end
  end

  // driver tasks
  task automatic send_pkt(input logic [W-1:0] d, input logic e, input int budget, output int lat);
    int n;
    Data_in = d;
    Exb_in  = e;
    Send_in = 1'b1;
    if (e == KEEP) exp_q.push_back(d);
    lat = 0;
    while (!Ack_out && lat < budget) begin
      @(negedge CP);
      lat++;
    end
    if (!Ack_out) begin
      lat = -1;
      return;
    end
    Send_in = 1'b0;
    n = 0;
    while (Ack_out && n < budget) begin
      @(negedge CP);
      n++;
    end
    check("ack_fall", {31'h0, Ack_out}, 32'h0);
  endtask

  task automatic do_reset();
    resp_en = 1'b0;
    Send_in = 1'b0;
    Exb_in  = 1'b0;
    Data_in = '0;
    MR_n    = 1'b0;
    repeat (3) @(negedge CP);
    exp_q.delete();
    MR_n = 1'b1;
    repeat (2) @(negedge CP);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !Send_out && rs == 0 && Count == 0) && n < budget) begin
      @(negedge CP);
      n++;
    end
    check("drain_done", {31'h0, (n < budget)}, 32'h1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int seen0;
    MR_n = 1'b0;
    Send_in = 1'b0;
    Exb_in = 1'b0;
    Data_in = '0;
    repeat (2) @(negedge CP);
    // reset state
    check("rst_ack", {31'h0, Ack_out}, 32'h0);
    check("rst_send", {31'h0, Send_out}, 32'h0);
    check("rst_data", {16'h0, Data_out}, 32'h0);
    check("rst_count", {28'h0, Count}, 32'h0);
    check("rst_empty", {31'h0, Empty}, 32'h1);
    check("rst_full", {31'h0, Full}, 32'h0);
    check("rst_drop", {28'h0, Drop_cnt}, 32'h0);
    do_reset();

    // single kept packet, responder acks 3 cycles after Send_out
    resp_min = 3; resp_max = 3; resp_en = 1'b1;
    seen0 = n_seen;
    Data_in = 16'hA5A5; Exb_in = KEEP; Send_in = 1'b1;
    exp_q.push_back(16'hA5A5);
    lat = 0;
    while (!Ack_out && lat < 20) begin @(negedge CP); lat++; end
    check("single_lat", lat, SS + 1);
    check("single_cnt1", {28'h0, Count}, 32'h1);
    Send_in = 1'b0;
    drain(100);
    check("single_seen", n_seen - seen0, 1);
    check("single_drop", {28'h0, Drop_cnt}, 32'h0);

    // deletion
    do_reset();
    resp_min = 0; resp_max = 2; resp_en = 1'b1;
    seen0 = n_seen;
    send_pkt(16'h0001, KEEP, 50, lat);   check("del_ack1", {31'h0, lat > 0}, 32'h1);
    send_pkt(16'h0002, DELETE, 50, lat); check("del_ack2", {31'h0, lat > 0}, 32'h1);
    send_pkt(16'h0003, KEEP, 50, lat);   check("del_ack3", {31'h0, lat > 0}, 32'h1);
    drain(200);
    check("del_seen", n_seen - seen0, 2);
    check("del_drop", {28'h0, Drop_cnt}, 32'h1);

    // full stall
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_pkt(W'(16'h10 + i), KEEP, 50, lat);
      check("full_ack", {31'h0, lat > 0}, 32'h1);
    end
    send_pkt(16'h0018, KEEP, 20, lat);
    check("full_noack", lat, -1);
    check("full_flag", {31'h0, Full}, 32'h1);
    check("full_count", {28'h0, Count}, 32'h8);
    Send_in = 1'b0;
    void'(exp_q.pop_back());
    repeat (4) @(negedge CP);
    send_pkt(16'h00EE, DELETE, 50, lat);
    check("full_del_ack", {31'h0, lat > 0}, 32'h1);
    check("full_del_drop", {28'h0, Drop_cnt}, 32'h1);
    resp_min = 0; resp_max = 1;
    seen0 = n_seen;
    fork
      send_pkt(16'h0018, KEEP, 300, lat);
      begin repeat (5) @(negedge CP); resp_en = 1'b1; end
    join
    check("full_9th_ack", {31'h0, lat > 0}, 32'h1);
    drain(400);
    check("full_seen", n_seen - seen0, 9);

    // wrap and concurrency
    do_reset();
    resp_min = 0; resp_max = 4; resp_en = 1'b1;
    max_count = 0;
    seen0 = n_seen;
    for (int i = 0; i < 26; i++) begin
      send_pkt(W'($urandom_range(16'hFFFF, 0)), KEEP, 200, lat);
      repeat ($urandom_range(2, 0)) @(negedge CP);
    end
    drain(1000);
    check("wrap_seen", n_seen - seen0, 26);
    check("wrap_max_cnt", {31'h0, max_count <= D}, 32'h1);

    // reset mid-operation
    do_reset();
    send_pkt(16'h00DD, DELETE, 50, lat);
    for (int i = 0; i < 3; i++) send_pkt(W'(16'h30 + i), KEEP, 50, lat);
    repeat (4) @(negedge CP);
    check("mid_tx_send", {30'h0, dbg_tx}, {30'h0, TX_SEND});
    check("mid_count3", {28'h0, Count}, 32'h3);
    check("mid_drop1", {28'h0, Drop_cnt}, 32'h1);
    #2 MR_n = 1'b0;
    #1;
    check("mr_send", {31'h0, Send_out}, 32'h0);
    check("mr_ack", {31'h0, Ack_out}, 32'h0);
    check("mr_count", {28'h0, Count}, 32'h0);
    check("mr_empty", {31'h0, Empty}, 32'h1);
    check("mr_drop", {28'h0, Drop_cnt}, 32'h0);
    @(negedge CP);
    do_reset();
    resp_en = 1'b1;
    seen0 = n_seen;
    send_pkt(16'h0055, KEEP, 50, lat);
    check("mr_resume_ack", {31'h0, lat > 0}, 32'h1);
    drain(200);
    check("mr_resume_seen", n_seen - seen0, 1);

    // drop saturation
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_pkt(W'(i), DELETE, 50, lat);
      if (i == 14) check("sat_15", {28'h0, Drop_cnt}, 32'hF);
    end
    check("sat_17", {28'h0, Drop_cnt}, 32'hF);
    check("sat_empty", {31'h0, Empty}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
